// File: rtl/scope_pkg.sv
// Shared state encoding, colour constants and pipeline depth for the scope renderer.
package scope_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } scope_state_e;

  localparam logic [7:0] TRACE_G    = 8'hFF;
  localparam logic [7:0] BG_LEVEL   = 8'h10;
  localparam logic [7:0] GRID_LEVEL = 8'h40;
  localparam int         RENDER_LAT = 2;

  // Screen row of a sample: 255 sits at top, 0 sits 255 lines below.
  function automatic logic [11:0] trace_row(input logic [11:0] top, input logic [7:0] sample);
    return top + {4'd0, 8'd255 - sample};
  endfunction

endpackage

// File: rtl/scope_dpram.sv
// Simple dual-port line store: one write port, one registered read port.
module scope_dpram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [0:2**AW-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/adc_scope_render.sv
// Single-channel scope pixel source: trigger, double-buffered capture, trace render.
// Optional graticule every 64 px enabled by defining SCOPE_GRID_EN.
//
// state   | meaning
// ARMED   | waiting for rising crossing or auto-trigger timeout
// CAPTURE | writing one sample per clock into the write bank
// FULL    | capture complete, waiting for a vsync edge to swap banks
module adc_scope_render
  import scope_pkg::*;
#(
  parameter int         SAMPLES      = 512,
  parameter int         TRIG_LEVEL   = 128,
  parameter int         AUTO_TIMEOUT = 1000000,
  parameter int         TRACE_TOP    = 112,
  parameter logic [7:0] BG_LEVEL     = scope_pkg::BG_LEVEL
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic [7:0]  adc_d,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_in,
  input  logic [11:0] pixel_count,
  input  logic [11:0] line_count,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic        triggered
);

  localparam int          AW        = $clog2(SAMPLES);
  localparam logic [12:0] SAMPLES_W = 13'(SAMPLES);
  localparam logic [7:0]  TRIG_W    = 8'(TRIG_LEVEL);
  localparam logic [31:0] TMO_LOAD  = (AUTO_TIMEOUT == 0) ? 32'd0 : 32'(AUTO_TIMEOUT - 1);
  localparam bit          AUTO_EN   = (AUTO_TIMEOUT != 0);

  logic [7:0]   s_cur_q, s_prev_q;
  logic         vs_q;
  scope_state_e state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]  tmo_q, tmo_d;
  logic         bank_q, bank_d;
  logic         disp_valid_q, disp_valid_d;
  logic         ready_q, ready_d;
  logic         trig_q, trig_d;

  logic trig_cond, vs_rise, last_wr, we;

  assign trig_cond = (s_prev_q < TRIG_W) && (s_cur_q >= TRIG_W);
  assign vs_rise   = vsync_in && !vs_q;
  assign we        = (state_q == CAPTURE);
  assign last_wr   = we && (&wr_addr_q);

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    tmo_d        = tmo_q;
    bank_d       = bank_q;
    disp_valid_d = disp_valid_q;
    ready_d      = ready_q;
    trig_d       = 1'b0;
    case (state_q)
      ARMED: begin
        if (trig_cond || (AUTO_EN && tmo_q == 32'd0)) begin
          trig_d    = 1'b1;
          wr_addr_d = '0;
          state_d   = CAPTURE;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end
      CAPTURE: begin
        wr_addr_d = wr_addr_q + AW'(1);
        if (last_wr) begin
          ready_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: ;
      default: state_d = ARMED;
    endcase
    // A capture completing on the vsync edge itself still makes this frame.
    if (vs_rise && (ready_q || last_wr)) begin
      bank_d       = ~bank_q;
      disp_valid_d = 1'b1;
      ready_d      = 1'b0;
      state_d      = ARMED;
      tmo_d        = TMO_LOAD;
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      s_cur_q      <= '0;
      s_prev_q     <= '0;
      vs_q         <= 1'b0;
      state_q      <= ARMED;
      wr_addr_q    <= '0;
      tmo_q        <= TMO_LOAD;
      bank_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      s_cur_q      <= adc_d;
      s_prev_q     <= s_cur_q;
      vs_q         <= vsync_in;
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      tmo_q        <= tmo_d;
      bank_q       <= bank_d;
      disp_valid_q <= disp_valid_d;
      ready_q      <= ready_d;
      trig_q       <= trig_d;
    end
  end

  assign triggered = trig_q;

  // s_prev is the crossing sample on the first CAPTURE cycle, so column 0 holds it.
  logic [7:0] rd_data;

  scope_dpram #(.AW(AW + 1)) u_ram (
    .clk_i   (clk_pixel),
    .we_i    (we),
    .waddr_i ({bank_q, wr_addr_q}),
    .wdata_i (s_prev_q),
    .raddr_i ({~bank_q, pixel_count[AW-1:0]}),
    .rdata_o (rd_data)
  );

  logic                  in_range_q;
  logic [11:0]           line1_q;
  logic [RENDER_LAT-1:0] hs_pipe_q, vs_pipe_q, act_pipe_q;
  logic [7:0]            red_q, green_q, blue_q, red_d, green_d, blue_d;
  logic                  lit, grid;

`ifdef SCOPE_GRID_EN
  logic grid1_q;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) grid1_q <= 1'b0;
    else         grid1_q <= (pixel_count[5:0] == 6'd0) || (line_count[5:0] == 6'd0);
  end

  assign grid = grid1_q;
`else
  assign grid = 1'b0;
`endif

  assign lit = in_range_q && disp_valid_q && (line1_q == trace_row(12'(TRACE_TOP), rd_data));

  always_comb begin
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    if (act_pipe_q[0]) begin
      if (lit) begin
        green_d = TRACE_G;
      end else if (grid) begin
        red_d   = GRID_LEVEL;
        green_d = GRID_LEVEL;
        blue_d  = GRID_LEVEL;
      end else begin
        red_d   = BG_LEVEL;
        green_d = BG_LEVEL;
        blue_d  = BG_LEVEL;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      in_range_q <= 1'b0;
      line1_q    <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      act_pipe_q <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      in_range_q <= {1'b0, pixel_count} < SAMPLES_W;
      line1_q    <= line_count;
      hs_pipe_q  <= {hs_pipe_q[RENDER_LAT-2:0], hsync_in};
      vs_pipe_q  <= {vs_pipe_q[RENDER_LAT-2:0], vsync_in};
      act_pipe_q <= {act_pipe_q[RENDER_LAT-2:0], active_in};
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign hsync_out  = hs_pipe_q[RENDER_LAT-1];
  assign vsync_out  = vs_pipe_q[RENDER_LAT-1];
  assign active_out = act_pipe_q[RENDER_LAT-1];

endmodule
